// File: rtl/mprjram_port_arbiter_if.sv
// Requester-side and controller-side signals of the mprjram command port arbiter.
// The arbiter uses the slave modport; the agent driving the requesters and controller uses master.
interface mprjram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]          req_valid;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                ctl_valid;
    logic                ctl_we;
    logic [ADDR_W-1:0]   ctl_addr;
    logic [DATA_W-1:0]   ctl_wdata;
    logic                ctl_ready;
    logic                ctl_rvalid;
    logic [DATA_W-1:0]   ctl_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ctl_valid, ctl_we, ctl_addr, ctl_wdata,
        input  ctl_ready, ctl_rvalid, ctl_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ctl_valid, ctl_we, ctl_addr, ctl_wdata,
        output ctl_ready, ctl_rvalid, ctl_rdata
    );
endinterface

// File: rtl/mprjram_port_arbiter.sv
// Round-robin arbiter sharing the mprjram controller command port between the Wishbone path
// (port 0) and the accelerator master (port 1); one transaction in flight, read timeout flag.
module mprjram_port_arbiter #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                   clock,
    input  logic                   resetb,
    mprjram_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_last_grant;
    logic              r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_ctl_valid;
    logic [1:0]        r_rsp_valid;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [TO_W-1:0]   w_to_cnt_inc;
    logic              w_to_hit;
    logic [1:0]        w_req_ready;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_rd_done;
    logic              w_rd_to;

    // Sole requester wins; on contention the port that was not served last wins.
    assign w_grant      = (&bus.req_valid) ? ~r_last_grant : bus.req_valid[1];
    assign w_sel_we     = w_grant ? bus.req_we[1] : bus.req_we[0];
    assign w_sel_addr   = w_grant ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
    assign w_sel_wdata  = w_grant ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    assign w_to_cnt_inc = r_to_cnt + TO_W'(1);
    assign w_to_hit     = (w_to_cnt_inc == TO_W'(TIMEOUT));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_accept    = 1'b0;
        w_wr_done   = 1'b0;
        w_rd_done   = 1'b0;
        w_rd_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_req_ready = w_grant ? 2'b10 : 2'b01;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ctl_ready) begin
                    if (r_we) begin
                        w_wr_done   = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                // Read data takes priority over a timeout expiring in the same cycle.
                if (bus.ctl_rvalid) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_to_hit) begin
                    w_rd_to     = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, response capture and timeout counter.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_ctl_valid  <= 1'b0;
            r_rsp_valid  <= 2'b00;
            r_to_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_grant <= w_grant;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (w_wr_done || w_rd_to) r_rdata <= '0;
            else if (w_rd_done)       r_rdata <= bus.ctl_rdata;
            r_err       <= w_rd_to;
            r_ctl_valid <= (w_state_nxt == S_ISSUE);
            r_rsp_valid <= (w_state_nxt == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
            if (r_state == S_RESP) r_last_grant <= r_grant;
            if (r_state == S_WAIT_RD) r_to_cnt <= w_to_cnt_inc;
            else                      r_to_cnt <= '0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.ctl_valid = r_ctl_valid;
    assign bus.ctl_we    = r_we;
    assign bus.ctl_addr  = r_addr;
    assign bus.ctl_wdata = r_wdata;

endmodule

// File: tb/tb_mprjram_port_arbiter.sv
// Directed bench for mprjram_port_arbiter: reset, write/read paths, controller stall,
// alternating grants, read timeout and reset abort.
module tb_mprjram_port_arbiter;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned DATA_W = 32;

    logic clock;
    logic resetb;
    int   n_tests = 0;
    int   n_fail  = 0;

    mprjram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mprjram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(255),
        .TO_W   (8)
    ) dut (
        .clock (clock),
        .resetb(resetb),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; drive and sample happen here.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int port, input logic v, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        bus.req_valid[port] = v;
        bus.req_we[port]    = we;
        bus.req_addr[port*ADDR_W +: ADDR_W]  = addr;
        bus.req_wdata[port*DATA_W +: DATA_W] = wdata;
    endtask

    // Single read from IDLE with ctl_ready=1; rvalid arrives lat cycles after the handshake.
    task automatic read_txn(input string tag, input int port, input logic [ADDR_W-1:0] addr,
                            input int lat, input logic [DATA_W-1:0] data);
        logic [1:0] onehot;
        onehot = (port == 1) ? 2'b10 : 2'b01;
        bus.ctl_ready = 1'b1;
        set_req(port, 1'b1, 1'b0, addr, '0);
        #1;
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(onehot));
        cyc();
        set_req(port, 1'b0, 1'b0, '0, '0);
        check({tag, "_ctl_valid"}, 64'(bus.ctl_valid), 64'd1);
        check({tag, "_ctl_addr"}, 64'(bus.ctl_addr), 64'(addr));
        cyc();
        repeat (lat - 1) cyc();
        bus.ctl_rvalid = 1'b1;
        bus.ctl_rdata  = data;
        cyc();
        bus.ctl_rvalid = 1'b0;
        bus.ctl_rdata  = '0;
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot));
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'(data));
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        cyc();
    endtask

    initial begin : stim
        int ngr;
        int nctl;
        int nrsp;
        int bad;
        int n;
        int last_port;
        int rsp_seen;

        resetb         = 1'b0;
        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.ctl_ready  = 1'b1;
        bus.ctl_rvalid = 1'b0;
        bus.ctl_rdata  = '0;
        repeat (2) cyc();

        // Reset state
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_ctl_valid", 64'(bus.ctl_valid), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_ctl_addr",  64'(bus.ctl_addr),  64'd0);

        // 1+2: both request at reset release; port 0 write wins
        resetb = 1'b1;
        set_req(0, 1'b1, 1'b1, 23'h000010, 32'hDEADBEEF);
        set_req(1, 1'b1, 1'b0, 23'h000020, 32'h0);
        #1;
        check("t1_grant0", 64'(bus.req_ready), 64'b01);
        cyc();
        bus.req_valid[0] = 1'b0;
        #1;
        check("t2_ctl_valid", 64'(bus.ctl_valid), 64'd1);
        check("t2_ctl_we",    64'(bus.ctl_we),    64'd1);
        check("t2_ctl_addr",  64'(bus.ctl_addr),  64'h10);
        check("t2_ctl_wdata", 64'(bus.ctl_wdata), 64'hDEADBEEF);
        check("t2_ready_off", 64'(bus.req_ready), 64'd0);
        cyc();
        check("t2_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        check("t2_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("t2_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("t2_ctl_idle",  64'(bus.ctl_valid), 64'd0);
        cyc();

        // 3: port 1 read with 3 stall cycles, rvalid 4 cycles after handshake
        #1;
        check("t3_grant1", 64'(bus.req_ready), 64'b10);
        bus.ctl_ready = 1'b0;
        cyc();
        bus.req_valid[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 64'(bus.ctl_valid), 64'd1);
            check("t3_stall_addr",  64'(bus.ctl_addr),  64'h20);
            check("t3_stall_we",    64'(bus.ctl_we),    64'd0);
            cyc();
        end
        check("t3_hs_valid", 64'(bus.ctl_valid), 64'd1);
        bus.ctl_ready = 1'b1;
        cyc();
        check("t3_ctl_drop", 64'(bus.ctl_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t3_no_rsp", 64'(bus.rsp_valid), 64'd0);
            cyc();
        end
        bus.ctl_rvalid = 1'b1;
        bus.ctl_rdata  = 32'h0000003E;
        cyc();
        bus.ctl_rvalid = 1'b0;
        bus.ctl_rdata  = '0;
        check("t3_rsp_valid", 64'(bus.rsp_valid), 64'b10);
        check("t3_rsp_rdata", 64'(bus.rsp_rdata), 64'h3E);
        check("t3_rsp_err",   64'(bus.rsp_err),   64'd0);
        cyc();

        // 4: continuous requests from both ports, 8 writes
        set_req(0, 1'b1, 1'b1, 23'h000100, 32'h11110000);
        set_req(1, 1'b1, 1'b1, 23'h000200, 32'h22220000);
        ngr = 0; nctl = 0; nrsp = 0; bad = 0; last_port = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.req_ready == 2'b11) bad++;
            if (bus.req_ready != 2'b00) begin
                last_port = bus.req_ready[1] ? 1 : 0;
                check("t4_grant_order", 64'(last_port), 64'(ngr % 2));
                ngr++;
            end
            if (bus.ctl_valid) begin
                nctl++;
                check("t4_ctl_addr", 64'(bus.ctl_addr), (last_port == 1) ? 64'h200 : 64'h100);
            end
            if (bus.rsp_valid != 2'b00) nrsp++;
            if (nrsp == 8) break;
            cyc();
        end
        bus.req_valid = 2'b00;
        check("t4_onehot", 64'(bad), 64'd0);
        check("t4_ngrants", 64'(ngr), 64'd8);
        check("t4_nctl", 64'(nctl), 64'd8);
        check("t4_nrsp", 64'(nrsp), 64'd8);
        cyc();

        // Read leaving non-zero rdata so the timeout zeroing is visible
        read_txn("pre5", 1, 23'h000050, 2, 32'h77777777);

        // 5: port 0 read timeout after 255 WAIT_RD cycles
        set_req(0, 1'b1, 1'b0, 23'h000030, '0);
        #1;
        check("t5_grant0", 64'(bus.req_ready), 64'b01);
        cyc();
        bus.req_valid[0] = 1'b0;
        n = 0;
        rsp_seen = 0;
        for (int c = 0; c < 300; c++) begin
            cyc();
            n++;
            if (bus.rsp_valid != 2'b00) begin
                rsp_seen = 1;
                break;
            end
        end
        check("t5_rsp_seen",  64'(rsp_seen), 64'd1);
        check("t5_latency",   64'(n), 64'd256);
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'b01);
        check("t5_rsp_err",   64'(bus.rsp_err),   64'd1);
        check("t5_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        cyc();
        read_txn("t5_next", 0, 23'h000034, 1, 32'h00000055);

        // 6: reset pulse during WAIT_RD aborts the read
        set_req(1, 1'b1, 1'b0, 23'h000040, '0);
        cyc();
        bus.req_valid[1] = 1'b0;
        cyc();
        cyc();
        resetb = 1'b0;
        #1;
        check("t6_ctl_valid", 64'(bus.ctl_valid), 64'd0);
        check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t6_ctl_addr",  64'(bus.ctl_addr),  64'd0);
        bus.ctl_rvalid = 1'b1;
        bus.ctl_rdata  = 32'h00000BAD;
        cyc();
        cyc();
        bus.ctl_rvalid = 1'b0;
        bus.ctl_rdata  = '0;
        resetb = 1'b1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (bus.rsp_valid != 2'b00) n++;
        end
        check("t6_no_rsp", 64'(n), 64'd0);
        read_txn("t6_fresh", 0, 23'h000044, 2, 32'hA5A50001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
